// File: rtl/route_lookup_ctrl_pkg.sv
// route_lookup_ctrl_pkg: table geometry, direction codes and controller states
`ifndef ROUTE_LOOKUP_DEFS
`define ROUTE_LOOKUP_DEFS
`define NUM_NODES 16
`define SIZE 4
`define BITS_DIR 3
`endif

package route_lookup_ctrl_pkg;
    localparam logic [`BITS_DIR-1:0] DIR_N = 3'd0;
    localparam logic [`BITS_DIR-1:0] DIR_E = 3'd1;
    localparam logic [`BITS_DIR-1:0] DIR_S = 3'd2;
    localparam logic [`BITS_DIR-1:0] DIR_W = 3'd3;
    localparam logic [`BITS_DIR-1:0] DIR_LOCAL = 3'd4;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/route_lookup_ctrl_arb.sv
// rr_arbiter5: one-hot round-robin grant among eligible requesters, searching from ptr+1
module rr_arbiter5 (
    input  logic [4:0] req,
    input  logic [4:0] mask,
    input  logic [2:0] ptr,
    output logic [4:0] gnt,
    output logic       vld,
    output logic [2:0] idx
);
    logic [3:0] p;
    always_comb begin
        vld = 1'b0;
        idx = '0;
        p = '0;
        // walk farthest to nearest so the port closest after ptr overwrites last
        for (int k = 5; k >= 1; k--) begin
            p = {1'b0, ptr} + 4'(k);
            p = (p >= 4'd5) ? p - 4'd5 : p;
            if (req[p[2:0]] && mask[p[2:0]]) begin
                vld = 1'b1;
                idx = p[2:0];
            end
        end
        gnt = vld ? 5'b1 << idx : '0;
    end
endmodule

// File: rtl/route_lookup_ctrl.sv
// route_lookup_ctrl: fills the routing table with XY defaults, then shares it between cfg writes and round-robin lookups
module route_lookup_ctrl
    import route_lookup_ctrl_pkg::*;
#(
    parameter int NODE_ID   = 0,
    parameter int MESH_COLS = 4,
    parameter int NUM_PORTS = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*`SIZE-1:0]     req_dest,
    output logic [NUM_PORTS-1:0]           rsp_valid,
    output logic [`BITS_DIR-1:0]           rsp_dir,
    input  logic                           cfg_wr_en,
    input  logic [`SIZE-1:0]               cfg_addr,
    input  logic [`BITS_DIR-1:0]           cfg_dir,
    output logic                           cfg_busy,
    output logic                           init_done,
    output logic [`SIZE-1:0]               tbl_addr,
    output logic                           tbl_wr_en,
    output logic [`BITS_DIR-1:0]           tbl_wr_data,
    input  logic [`BITS_DIR-1:0]           tbl_rd_data
);
    function automatic logic [`BITS_DIR-1:0] xy_dir(input int node, input int dest);
        int x, y, dx, dy;
        x = node % MESH_COLS;
        y = node / MESH_COLS;
        dx = dest % MESH_COLS;
        dy = dest / MESH_COLS;
        return dx > x ? DIR_E : dx < x ? DIR_W : dy > y ? DIR_S : dy < y ? DIR_N : DIR_LOCAL;
    endfunction

    state_t                 state_q, state_d;
    logic [`SIZE-1:0]       cnt_q, cnt_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
    logic [`BITS_DIR-1:0]   rsp_dir_q, rsp_dir_d;
    logic                   init_done_q, init_done_d;
    logic                   cfg_busy_q, cfg_busy_d;
    logic [`SIZE-1:0]       addr_q, addr_d;
    logic [4:0]             gnt;
    logic                   gnt_vld;
    logic [2:0]             gnt_idx;
    logic [`SIZE-1:0]       dest_sel;

    // a port granted last cycle is still seeing its response and sits out one round
    rr_arbiter5 u_arb (
        .req  (req),
        .mask (~rsp_valid_q),
        .ptr  (ptr_q),
        .gnt  (gnt),
        .vld  (gnt_vld),
        .idx  (gnt_idx)
    );

    always_comb begin
        dest_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            dest_sel |= gnt[i] ? req_dest[i*`SIZE +: `SIZE] : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        rsp_valid_d = '0;
        rsp_dir_d = rsp_dir_q;
        tbl_wr_en = 1'b0;
        tbl_wr_data = '0;
        tbl_addr = addr_q;
        if (state_q == ST_INIT) begin
            tbl_wr_en = 1'b1;
            tbl_addr = cnt_q;
            tbl_wr_data = xy_dir(NODE_ID, int'(cnt_q));
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == `SIZE'(`NUM_NODES - 1)) ? ST_RUN : ST_INIT;
        end else if (cfg_wr_en) begin
            tbl_wr_en = 1'b1;
            tbl_addr = cfg_addr;
            tbl_wr_data = cfg_dir;
        end else if (gnt_vld) begin
            tbl_addr = dest_sel;
            rsp_valid_d = gnt;
            rsp_dir_d = tbl_rd_data;
            ptr_d = gnt_idx;
        end
        if (reset) begin
            tbl_wr_en = 1'b0;
            tbl_addr = '0;
            tbl_wr_data = '0;
        end
        addr_d = tbl_addr;
        init_done_d = state_d == ST_RUN;
        cfg_busy_d = state_d == ST_INIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q <= '0;
            ptr_q <= 3'd4;
            rsp_valid_q <= '0;
            rsp_dir_q <= '0;
            init_done_q <= 1'b0;
            cfg_busy_q <= 1'b1;
            addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dir_q <= rsp_dir_d;
            init_done_q <= init_done_d;
            cfg_busy_q <= cfg_busy_d;
            addr_q <= addr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_dir = rsp_dir_q;
    assign init_done = init_done_q;
    assign cfg_busy = cfg_busy_q;
endmodule
